// File: rtl/scope_pkg.sv
// -----------------------------------------------------------------------------
// scope_pkg
//   Definitions shared by the scope capture and dump blocks.
//   - SMPL_DEPTH   : number of samples in each circular capture buffer
//   - CH1..CH3     : channel-select codes on the dump command
//   - CH_INV       : the unused select code, rejected with dump_err
//   - dump_state_t : state encoding of the channel dump sequencer
// -----------------------------------------------------------------------------
package scope_pkg;

  localparam int SMPL_DEPTH = 512;

  localparam logic [1:0] CH1    = 2'd0;
  localparam logic [1:0] CH2    = 2'd1;
  localparam logic [1:0] CH3    = 2'd2;
  localparam logic [1:0] CH_INV = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LATCH   = 3'd2,
    WAIT_TX = 3'd3,
    FIN     = 3'd4
  } dump_state_t;

endpackage : scope_pkg

// File: rtl/channel_dump.sv
// -----------------------------------------------------------------------------
// channel_dump
//   Drains one captured channel from the circular capture RAM and streams it,
//   one byte at a time, to the UART transmitter. The dump starts at the oldest
//   sample (the capture write pointer at capture done) and walks the whole
//   buffer once, wrapping at the end, so exactly 2^DEPTH_W bytes are sent.
//   On completion dump_fin and clr_cap_done pulse together, releasing the
//   capture FSM from its DONE state.
//
// Ports
//   clk, rst_n                 system clock, asynchronous active-low reset
//   dump                       one-cycle dump request (ignored while busy)
//   dump_chan[1:0]             0/1/2 = CH1/CH2/CH3, 3 = invalid
//   start_addr[DEPTH_W-1:0]    oldest-sample address, sampled with dump
//   rdata_ch1..3[DATA_W-1:0]   synchronous RAM data, valid cycle after ram_en
//   tx_done                    UART has shifted out the current byte
//   ram_addr, ram_en           RAM read port
//   tx_data, trmt              byte to send and one-cycle UART start strobe
//   busy                       high from dump acceptance until dump_fin
//   dump_fin                   one-cycle pulse, dump complete (or rejected)
//   clr_cap_done               one-cycle pulse with dump_fin on a real dump
//   dump_err                   one-cycle pulse, invalid channel requested
// -----------------------------------------------------------------------------
module channel_dump
  import scope_pkg::*;
#(
  parameter int DEPTH_W = 9,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dump,
  input  logic [1:0]         dump_chan,
  input  logic [DEPTH_W-1:0] start_addr,
  input  logic [DATA_W-1:0]  rdata_ch1,
  input  logic [DATA_W-1:0]  rdata_ch2,
  input  logic [DATA_W-1:0]  rdata_ch3,
  input  logic               tx_done,
  output logic [DEPTH_W-1:0] ram_addr,
  output logic               ram_en,
  output logic [DATA_W-1:0]  tx_data,
  output logic               trmt,
  output logic               busy,
  output logic               dump_fin,
  output logic               clr_cap_done,
  output logic               dump_err
);

  dump_state_t        state_q, state_d;

  logic [1:0]         chan_q;     // channel latched at acceptance
  logic [DEPTH_W-1:0] ptr_q;      // current read address, wraps mod depth
  logic [DEPTH_W-1:0] cnt_q;      // samples already sent in this dump
  logic [DATA_W-1:0]  tx_data_q;
  logic [DATA_W-1:0]  sel_data;
  logic               trmt_q;
  logic               fin_q;
  logic               clr_q;
  logic               err_q;

  logic               req_idle;
  logic               accept;
  logic               reject;
  logic               last_smpl;
  logic               byte_done;

  // A request only counts in IDLE; while busy it is silently dropped.
  assign req_idle  = (state_q == IDLE) && dump;
  assign accept    = req_idle && (dump_chan != CH_INV);
  assign reject    = req_idle && (dump_chan == CH_INV);

  // The counter reaching all-ones means the byte in flight is the last of
  // the buffer; tx_done is only meaningful while waiting on the UART.
  assign last_smpl = (cnt_q == {DEPTH_W{1'b1}});
  assign byte_done = (state_q == WAIT_TX) && tx_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is given a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RD;
        end
      end
      RD: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          state_d = last_smpl ? FIN : RD;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel select: RAM data of the latched channel. The invalid code never
  // reaches here because it is rejected before chan_q is loaded.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_data = '0;
    unique case (chan_q)
      CH1:     sel_data = rdata_ch1;
      CH2:     sel_data = rdata_ch2;
      CH3:     sel_data = rdata_ch3;
      default: sel_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read pointer, sample counter and latched channel
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q <= CH1;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      chan_q <= dump_chan;
      ptr_q  <= start_addr;
      cnt_q  <= '0;
    end else if (byte_done && !last_smpl) begin
      // Pointer width equals the buffer address width, so the increment
      // wraps from the top of the buffer back to address 0 on its own.
      ptr_q  <= ptr_q + DEPTH_W'(1);
      cnt_q  <= cnt_q + DEPTH_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered UART byte, strobe and completion pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
      trmt_q    <= 1'b0;
      fin_q     <= 1'b0;
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // tx_data only changes in LATCH, so it is stable for the whole UART
      // transfer and until the next byte is fetched.
      if (state_q == LATCH) begin
        tx_data_q <= sel_data;
      end
      trmt_q <= (state_q == LATCH);
      // A rejected request reports completion immediately but does not
      // release the capture block, since nothing was drained.
      fin_q  <= (state_q == FIN) || reject;
      clr_q  <= (state_q == FIN);
      err_q  <= reject;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_en       = (state_q == RD);
  assign ram_addr     = ptr_q;
  assign tx_data      = tx_data_q;
  assign trmt         = trmt_q;
  assign busy         = (state_q != IDLE);
  assign dump_fin     = fin_q;
  assign clr_cap_done = clr_q;
  assign dump_err     = err_q;

endmodule : channel_dump

// File: tb/tb_channel_dump.sv
// -----------------------------------------------------------------------------
// tb_channel_dump
//   Self-checking bench for channel_dump. A synchronous three-channel RAM and
//   a UART with programmable latency surround the DUT. A transaction-level
//   model (expected byte stream = mem[chan][(start + i) mod 512], plus the
//   event latencies of the dump protocol) is compared against the DUT on
//   every cycle, and each scenario adds a few literal expectations.
// -----------------------------------------------------------------------------
module tb_channel_dump;

  logic       clk;
  logic       rst_n;
  logic       dump;
  logic [1:0] dump_chan;
  logic [8:0] start_addr;
  logic [7:0] rdata_ch1, rdata_ch2, rdata_ch3;
  logic       tx_done;
  logic [8:0] ram_addr;
  logic       ram_en;
  logic [7:0] tx_data;
  logic       trmt;
  logic       busy;
  logic       dump_fin;
  logic       clr_cap_done;
  logic       dump_err;

  channel_dump #(.DEPTH_W(9), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump         (dump),
    .dump_chan    (dump_chan),
    .start_addr   (start_addr),
    .rdata_ch1    (rdata_ch1),
    .rdata_ch2    (rdata_ch2),
    .rdata_ch3    (rdata_ch3),
    .tx_done      (tx_done),
    .ram_addr     (ram_addr),
    .ram_en       (ram_en),
    .tx_data      (tx_data),
    .trmt         (trmt),
    .busy         (busy),
    .dump_fin     (dump_fin),
    .clr_cap_done (clr_cap_done),
    .dump_err     (dump_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check task
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Capture RAM: synchronous read, data valid the cycle after ram_en
  // ---------------------------------------------------------------------------
  logic [7:0] mem [3][512];

  initial begin
    rdata_ch1 = '0;
    rdata_ch2 = '0;
    rdata_ch3 = '0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      rdata_ch1 <= mem[0][ram_addr];
      rdata_ch2 <= mem[1][ram_addr];
      rdata_ch3 <= mem[2][ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // UART model: tx_done tx_lat cycles after trmt; optional spurious pulses
  // while no byte is outstanding.
  // ---------------------------------------------------------------------------
  int tx_lat   = 10;
  bit spurious = 1'b0;

  initial begin
    int tx_cnt;
    tx_cnt  = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        tx_cnt  = 0;
        tx_done = 1'b0;
      end else if (trmt) begin
        tx_cnt  = tx_lat;
        tx_done = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        tx_done = (tx_cnt == 0);
      end else begin
        tx_done = spurious && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  bit         m_act = 1'b0;
  int         acc_c = -1, end_c = -1, rd_c = -1, trmt_c = -1, fin_c = -1, err_c = -1;
  bit         fin_clr = 1'b0;
  bit         waiting = 1'b0;
  int         idx = 0;
  logic [1:0] m_chan = 2'd0;
  logic [8:0] m_start = 9'd0;

  // Observations used by the scenario-level literal checks
  logic [7:0] got_bytes[$];
  logic [8:0] got_addr[$];
  int         trmt_cyc[$];
  int         n_fin = 0, n_clr = 0, n_err = 0, n_ramen = 0;
  int         dump_cyc = 0, last_txd = 0, fin_cyc = 0;

  function automatic logic [8:0] addr_of(input int i);
    return 9'((int'(m_start) + i) % 512);
  endfunction

  always @(negedge clk) begin
    logic       exp_busy;
    logic [8:0] a;
    cyc++;
    if (!rst_n) begin
      m_act   = 1'b0;
      rd_c    = -1;
      trmt_c  = -1;
      fin_c   = -1;
      err_c   = -1;
      end_c   = -1;
      waiting = 1'b0;
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_trmt", trmt, 0);
      check("rst_busy", busy, 0);
      check("rst_dump_fin", dump_fin, 0);
      check("rst_clr_cap_done", clr_cap_done, 0);
      check("rst_dump_err", dump_err, 0);
    end else begin
      exp_busy = m_act && (cyc > acc_c) && (end_c < 0 || cyc < end_c);
      a        = addr_of(idx);
      check("busy", busy, exp_busy);
      check("ram_en", ram_en, cyc == rd_c);
      if (cyc == rd_c) check("ram_addr", ram_addr, a);
      check("trmt", trmt, cyc == trmt_c);
      if (cyc == trmt_c) check("tx_data", tx_data, mem[m_chan][a]);
      check("dump_fin", dump_fin, cyc == fin_c);
      check("clr_cap_done", clr_cap_done, (cyc == fin_c) && fin_clr);
      check("dump_err", dump_err, cyc == err_c);

      if (dump)         dump_cyc = cyc;
      if (tx_done)      last_txd = cyc;
      if (trmt)         begin got_bytes.push_back(tx_data); trmt_cyc.push_back(cyc); end
      if (ram_en)       begin got_addr.push_back(ram_addr); n_ramen++; end
      if (dump_fin)     begin n_fin++; fin_cyc = cyc; end
      if (clr_cap_done) n_clr++;
      if (dump_err)     n_err++;

      if (cyc == trmt_c) waiting = 1'b1;
      if (m_act && end_c >= 0 && cyc >= end_c) m_act = 1'b0;

      if (dump && !exp_busy) begin
        if (dump_chan == 2'd3) begin
          err_c   = cyc + 1;
          fin_c   = cyc + 1;
          fin_clr = 1'b0;
        end else begin
          m_act   = 1'b1;
          acc_c   = cyc;
          end_c   = -1;
          rd_c    = cyc + 1;
          trmt_c  = cyc + 3;
          idx     = 0;
          waiting = 1'b0;
          m_chan  = dump_chan;
          m_start = start_addr;
        end
      end else if (tx_done && waiting) begin
        waiting = 1'b0;
        if (idx == 511) begin
          fin_c   = cyc + 2;
          fin_clr = 1'b1;
          end_c   = cyc + 2;
        end else begin
          idx++;
          rd_c   = cyc + 1;
          trmt_c = cyc + 3;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_mon();
    got_bytes.delete();
    got_addr.delete();
    trmt_cyc.delete();
    n_fin   = 0;
    n_clr   = 0;
    n_err   = 0;
    n_ramen = 0;
  endtask

  task automatic start_dump(input logic [1:0] ch, input logic [8:0] sa);
    @(posedge clk);
    #1;
    dump       = 1'b1;
    dump_chan  = ch;
    start_addr = sa;
    @(posedge clk);
    #1;
    dump       = 1'b0;
    dump_chan  = 2'($urandom_range(0, 3));
    start_addr = 9'($urandom);
  endtask

  task automatic wait_fin(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dump_fin) begin
        seen = 1'b1;
        break;
      end
    end
    check("dump_fin_seen", seen, 1);
    @(negedge clk);
    check("busy_after_fin", busy, 0);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got_bytes.size() >= n) begin
        seen = 1'b1;
        break;
      end
    end
    check("byte_count_reached", seen, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int         bad;
    logic [8:0] sa;
    logic [1:0] ch;

    rst_n      = 1'b1;
    dump       = 1'b0;
    dump_chan  = 2'd0;
    start_addr = 9'd0;
    for (int i = 0; i < 512; i++) begin
      mem[0][i] = 8'(i);
      mem[1][i] = 8'($urandom);
      mem[2][i] = 8'($urandom);
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic dump: CH1 holds i[7:0], start 0, UART latency 10.
    tx_lat = 10;
    clear_mon();
    start_dump(2'd0, 9'd0);
    wait_fin(512 * 16 + 50);
    check("basic_bytes", got_bytes.size(), 512);
    check("basic_byte0", got_bytes[0], 8'h00);
    check("basic_byte255", got_bytes[255], 8'hFF);
    check("basic_byte256", got_bytes[256], 8'h00);
    check("basic_byte511", got_bytes[511], 8'hFF);
    check("basic_fin_count", n_fin, 1);
    check("basic_clr_count", n_clr, 1);

    // Wrap-around: CH3 from 0x1F5, random short UART latency.
    tx_lat = $urandom_range(1, 4);
    clear_mon();
    start_dump(2'd2, 9'h1F5);
    wait_fin(512 * 10 + 50);
    check("wrap_addrs", got_addr.size(), 512);
    check("wrap_addr0", got_addr[0], 9'h1F5);
    check("wrap_addr10", got_addr[10], 9'h1FF);
    check("wrap_addr11", got_addr[11], 9'h000);
    check("wrap_addr_last", got_addr[511], 9'h1F4);
    check("wrap_byte0", got_bytes[0], mem[2][9'h1F5]);

    // Back-to-back: tx_done the cycle after every trmt.
    tx_lat = 1;
    clear_mon();
    sa = 9'($urandom);
    start_dump(2'd1, sa);
    wait_fin(512 * 6 + 50);
    check("b2b_first_trmt_latency", trmt_cyc[0] - dump_cyc, 3);
    bad = 0;
    for (int i = 1; i < trmt_cyc.size(); i++) begin
      if (trmt_cyc[i] - trmt_cyc[i-1] != 4) bad++;
    end
    check("b2b_trmt_period_bad", bad, 0);
    check("b2b_fin_latency", fin_cyc - last_txd, 2);

    // Dump while busy: second request at byte 100 must be ignored.
    tx_lat = 1;
    clear_mon();
    sa = 9'($urandom);
    start_dump(2'd0, sa);
    wait_bytes(100, 1000);
    start_dump(2'd1, 9'($urandom));
    wait_fin(512 * 6 + 50);
    check("busy_bytes", got_bytes.size(), 512);
    check("busy_fin_count", n_fin, 1);
    bad = 0;
    for (int i = 0; i < got_bytes.size(); i++) begin
      if (got_bytes[i] !== mem[0][9'((int'(sa) + i) % 512)]) bad++;
    end
    check("busy_ch1_bad", bad, 0);

    // Reset mid-dump at byte 300, then a fresh dump.
    tx_lat = 2;
    clear_mon();
    start_dump(2'd2, 9'($urandom));
    wait_bytes(300, 2000);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ram_en", ram_en, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_ram_addr", ram_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_fin", n_fin, 0);
    clear_mon();
    sa = 9'h0A3;
    start_dump(2'd1, sa);
    wait_fin(512 * 7 + 50);
    check("postrst_bytes", got_bytes.size(), 512);
    check("postrst_addr0", got_addr[0], 9'h0A3);

    // Invalid channel.
    clear_mon();
    start_dump(2'd3, 9'($urandom));
    repeat (4) @(negedge clk);
    check("inv_err_count", n_err, 1);
    check("inv_fin_count", n_fin, 1);
    check("inv_clr_count", n_clr, 0);
    check("inv_ram_en_count", n_ramen, 0);
    check("inv_trmt_count", trmt_cyc.size(), 0);

    // Randomized dumps with spurious tx_done while no byte is outstanding.
    spurious = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ch     = 2'($urandom_range(0, 3));
      tx_lat = $urandom_range(1, 5);
      clear_mon();
      start_dump(ch, 9'($urandom));
      if (ch == 2'd3) begin
        repeat (4) @(negedge clk);
      end else begin
        wait_fin(512 * 10 + 50);
        check("rand_bytes", got_bytes.size(), 512);
      end
    end
    spurious = 1'b0;

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_channel_dump
